// File: rtl/calc_ctrl.sv
// calc_ctrl: four-digit decimal calculator controller with button edge detection and a display mux
module calc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_digit,
    input  logic        btn_op,
    input  logic        btn_eq,
    input  logic        btn_clr,
    input  logic [3:0]  sw_val,
    input  logic [1:0]  sw_op,
    output logic [26:0] disp_val,
    output logic        disp_neg,
    output logic        err,
    output logic        res_valid,
    output logic [1:0]  state_o
);
    typedef enum logic [1:0] {
        ENTER_A  = 2'b00,
        ENTER_B  = 2'b01,
        SHOW_RES = 2'b10,
        ERROR    = 2'b11
    } state_t;
    state_t      state;
    logic [3:0]  prev;
    logic [3:0]  btn;
    logic [3:0]  pulse;
    logic [13:0] a;
    logic [13:0] b;
    logic [26:0] result;
    logic        neg;
    logic [1:0]  op;
    logic [13:0] cur;
    logic [17:0] acc;
    logic        dig_ok;
    logic        val_ok;
    logic [26:0] sum;
    logic [26:0] diff;
    logic [26:0] prod;
    assign btn    = {btn_clr, btn_eq, btn_op, btn_digit};
    assign pulse  = btn & ~prev;
    assign val_ok = sw_val <= 4'd9;
    assign cur    = state == ENTER_B ? b : a;
    assign acc    = 18'(cur) * 18'd10 + 18'(sw_val);
    assign dig_ok = val_ok && acc <= 18'd9999;
    assign sum    = 27'(a) + 27'(b);
    assign diff   = b > a ? 27'(b - a) : 27'(a - b);
    assign prod   = 27'(a) * 27'(b);
    // One pulse per cycle is acted on: clr > eq > op > digit, the rest are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ENTER_A;
            prev      <= 4'hf;
            a         <= '0;
            b         <= '0;
            result    <= '0;
            neg       <= 1'b0;
            op        <= 2'b00;
            res_valid <= 1'b0;
        end else begin
            prev      <= btn;
            res_valid <= 1'b0;
            if (pulse[3]) begin
                state  <= ENTER_A;
                a      <= '0;
                b      <= '0;
                result <= '0;
                neg    <= 1'b0;
                op     <= 2'b00;
            end else begin
                case (state)
                    ENTER_A: begin
                        if (pulse[2]) begin
                        end else if (pulse[1]) begin
                            op    <= sw_op;
                            b     <= '0;
                            state <= ENTER_B;
                        end else if (pulse[0] && dig_ok) begin
                            a <= acc[13:0];
                        end
                    end
                    ENTER_B: begin
                        if (pulse[2]) begin
                            if (op == 2'b11) begin
                                state <= ERROR;
                            end else begin
                                result    <= op == 2'b00 ? sum : op == 2'b01 ? diff : prod;
                                neg       <= op == 2'b01 && b > a;
                                res_valid <= 1'b1;
                                state     <= SHOW_RES;
                            end
                        end else if (pulse[1]) begin
                            op <= sw_op;
                        end else if (pulse[0] && dig_ok) begin
                            b <= acc[13:0];
                        end
                    end
                    SHOW_RES: begin
                        if (pulse[2]) begin
                        end else if (pulse[1]) begin
                            if (!neg && result <= 27'd9999) begin
                                a     <= result[13:0];
                                op    <= sw_op;
                                b     <= '0;
                                state <= ENTER_B;
                            end else begin
                                state <= ERROR;
                            end
                        end else if (pulse[0]) begin
                            a     <= val_ok ? 14'(sw_val) : '0;
                            b     <= '0;
                            state <= ENTER_A;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
    always_comb begin
        disp_val = state == ENTER_A ? 27'(a) : state == ENTER_B ? 27'(b) : state == SHOW_RES ? result : '0;
        disp_neg = state == SHOW_RES && neg;
    end
    assign err     = state == ERROR;
    assign state_o = state;
endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: directed-vector bench for calc_ctrl with hand-computed expectations
module tb_calc_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_digit = 1'b0;
    logic        btn_op = 1'b0;
    logic        btn_eq = 1'b0;
    logic        btn_clr = 1'b0;
    logic [3:0]  sw_val = '0;
    logic [1:0]  sw_op = '0;
    logic [26:0] disp_val;
    logic        disp_neg;
    logic        err;
    logic        res_valid;
    logic [1:0]  state_o;
    int          n_chk = 0;
    int          n_bad = 0;
    calc_ctrl dut (
        .clk(clk), .rst(rst), .btn_digit(btn_digit), .btn_op(btn_op), .btn_eq(btn_eq),
        .btn_clr(btn_clr), .sw_val(sw_val), .sw_op(sw_op), .disp_val(disp_val),
        .disp_neg(disp_neg), .err(err), .res_valid(res_valid), .state_o(state_o)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // One idle edge with buttons low, then the mask {clr,eq,op,digit} high for one edge; returns 1ns after that edge.
    task automatic tap(input logic [3:0] m);
        @(posedge clk); #1;
        {btn_clr, btn_eq, btn_op, btn_digit} = m;
        @(posedge clk); #1;
        {btn_clr, btn_eq, btn_op, btn_digit} = 4'b0000;
    endtask
    task automatic dig(input logic [3:0] v);
        sw_val = v;
        tap(4'b0001);
    endtask
    task automatic opr(input logic [1:0] o);
        sw_op = o;
        tap(4'b0010);
    endtask
    task automatic idle();
        @(posedge clk); #1;
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_disp", 32'(disp_val), 0);
        check("rst_neg", 32'(disp_neg), 0);
        check("rst_err", 32'(err), 0);
        check("rst_state", 32'(state_o), 0);
        check("rst_rv", 32'(res_valid), 0);
        dig(1); dig(2); dig(3);
        check("a_123", 32'(disp_val), 123);
        opr(2'b00);
        check("b_state", 32'(state_o), 1);
        check("b_clear", 32'(disp_val), 0);
        dig(4); dig(5);
        check("b_45", 32'(disp_val), 45);
        tap(4'b0100);
        check("add_val", 32'(disp_val), 168);
        check("add_neg", 32'(disp_neg), 0);
        check("add_state", 32'(state_o), 2);
        check("add_rv1", 32'(res_valid), 1);
        idle();
        check("add_rv0", 32'(res_valid), 0);
        tap(4'b1000);
        dig(5); opr(2'b01); dig(1); dig(2);
        tap(4'b0100);
        check("sub_val", 32'(disp_val), 7);
        check("sub_neg", 32'(disp_neg), 1);
        opr(2'b00);
        check("neg_op_state", 32'(state_o), 3);
        check("neg_op_err", 32'(err), 1);
        check("err_disp", 32'(disp_val), 0);
        dig(3); tap(4'b0100);
        check("err_ignore", 32'(state_o), 3);
        tap(4'b1000);
        check("clr_state", 32'(state_o), 0);
        check("clr_disp", 32'(disp_val), 0);
        check("clr_err", 32'(err), 0);
        repeat (4) dig(9);
        check("a_9999", 32'(disp_val), 9999);
        opr(2'b10);
        repeat (4) dig(9);
        tap(4'b0100);
        check("mul_max", 32'(disp_val), 99980001);
        check("mul_neg", 32'(disp_neg), 0);
        dig(5);
        check("res_dig_state", 32'(state_o), 0);
        check("res_dig_val", 32'(disp_val), 5);
        tap(4'b1000);
        dig(1); dig(2); dig(3); dig(4); dig(5);
        check("ovf_ignore", 32'(disp_val), 1234);
        dig(4'd12);
        check("bad_dig", 32'(disp_val), 1234);
        tap(4'b0100);
        check("eq_in_a", 32'(state_o), 0);
        sw_op = 2'b01; sw_val = 4'd6;
        tap(4'b0011);
        check("op_over_dig_st", 32'(state_o), 1);
        check("op_over_dig_b", 32'(disp_val), 0);
        tap(4'b1000);
        dig(3); opr(2'b00); dig(4);
        tap(4'b1100);
        check("clr_over_eq_st", 32'(state_o), 0);
        check("clr_over_eq_rv", 32'(res_valid), 0);
        check("clr_over_eq_val", 32'(disp_val), 0);
        dig(3); opr(2'b00); dig(4);
        idle();
        btn_eq = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        btn_eq = 1'b0; rst = 1'b0;
        check("rst_over_eq_st", 32'(state_o), 0);
        check("rst_over_eq_rv", 32'(res_valid), 0);
        sw_val = 4'd7; btn_digit = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) idle();
        check("held_no_dig", 32'(disp_val), 0);
        btn_digit = 1'b0;
        dig(7);
        check("repress_dig", 32'(disp_val), 7);
        tap(4'b1000);
        dig(2); opr(2'b00); dig(3); tap(4'b0100);
        check("chain_5", 32'(disp_val), 5);
        opr(2'b10);
        check("chain_op_st", 32'(state_o), 1);
        dig(4); tap(4'b0100);
        check("chain_20", 32'(disp_val), 20);
        check("chain_rv", 32'(res_valid), 1);
        opr(2'b11);
        check("inv_op_st", 32'(state_o), 1);
        tap(4'b0100);
        check("inv_eq_err", 32'(err), 1);
        check("inv_eq_rv", 32'(res_valid), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 Parameters: none; operand limit fixed at 9999 (4 decimal digits), result width fixed at 27 bits.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  reset rst, synchronous, active-high; clock clk.
REQ-004 btn_digit  input  1  debounced level; rising edge enters the digit on sw_val.
REQ-005 btn_op  input  1  debounced level; rising edge latches the operator on sw_op.
REQ-006 btn_eq  input  1  debounced level; rising edge evaluates the expression.
REQ-007 btn_clr  input  1  debounced level; rising edge clears all state.
REQ-008 sw_val  input  4  digit value; 0-9 valid.
REQ-009 sw_op  input  2  operator: 00 add, 01 sub, 10 mul, 11 invalid.
REQ-010 disp_val  output  27  unsigned magnitude to display.
REQ-011 disp_neg  output  1  disp_val is negative.
REQ-012 err  output  1  block is in ERROR.
REQ-013 res_valid  output  1  single-cycle pulse when a result is latched.
REQ-014 state_o  output  2  current state: 00 ENTER_A, 01 ENTER_B, 10 SHOW_RES, 11 ERROR.

Function
REQ-015 Each button SHALL pass through a registered edge detector; pulse = level & ~prev; exactly one pulse per 0->1 transition.
REQ-016 Edge-detector prev registers SHALL reset to 1, so a button held through reset SHALL produce no pulse until released and pressed again.
REQ-017 Pulses in the same cycle SHALL be prioritised clr > eq > op > digit; lower-priority pulses SHALL be dropped, not queued.
REQ-018 Digit entry: operand <= operand*10 + sw_val, applied on the pulse cycle and visible on disp_val the next cycle.
REQ-019 Digit with sw_val > 9, or one whose result would exceed 9999, SHALL be ignored; operand unchanged, no error.
REQ-020 ENTER_A: digit accumulates into A; op latches sw_op, clears B, goes to ENTER_B; eq ignored.
REQ-021 ENTER_B: digit accumulates into B; op re-latches sw_op, stays; eq evaluates.
REQ-022 Evaluation: add A+B; sub |A-B| with neg=(B>A); mul A*B (max 99 980 001, fits 27 bits); result and neg registered on the eq cycle, next state SHOW_RES, res_valid=1 for that following cycle only.
REQ-023 Evaluation with latched op 11 SHALL go to ERROR; no res_valid.
REQ-024 SHOW_RES: digit loads A=sw_val (if valid, else A=0), clears B, goes to ENTER_A; eq ignored.
REQ-025 SHOW_RES op: if neg=0 and result <= 9999, A <= result, latch sw_op, B <= 0, go to ENTER_B; otherwise go to ERROR.
REQ-026 ERROR: all pulses except clr ignored.
REQ-027 clr from any state: A=B=result=0, neg=0, op=00, go to ENTER_A, in one cycle.
REQ-028 Display mux (registered state, combinational mux): ENTER_A -> A, neg 0; ENTER_B -> B, neg 0; SHOW_RES -> result, neg; ERROR -> 0, neg 0, err=1.
REQ-029 err SHALL equal (state == ERROR); no other source.

Reset
REQ-030 On rst: state ENTER_A, A=B=result=0, neg=0, op=00, res_valid=0, prev regs=1; outputs disp_val=0, disp_neg=0, err=0, state_o=00 from the next cycle.
REQ-031 rst SHALL take precedence over every pulse, including mid-entry and same-cycle eq.

Verification
REQ-032 Digits 1,2,3, op add(00), digits 4,5, eq -> disp_val=168, disp_neg=0, state_o=10, res_valid one cycle.
REQ-033 A=5, op sub(01), B=12, eq -> disp_val=7, disp_neg=1; then op -> state_o=11, err=1; clr -> state_o=00, disp_val=0.
REQ-034 A=9999, op mul, B=9999, eq -> disp_val=99980001; digit 5 -> state_o=00, disp_val=5.
REQ-035 Entering 1,2,3,4 then 5 -> disp_val stays 1234; sw_val=12 pulse -> ignored.
REQ-036 btn_eq and btn_clr rise same cycle in ENTER_B -> clr wins, state_o=00, no res_valid; btn_digit held high across rst -> no digit entered until re-pressed.
REQ-037 Chain: 2 + 3 eq (5), op mul, 4, eq -> disp_val=20; op 11 selected then eq -> err=1.
